// File: rtl/arbitro_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package arbitro_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EMITE    = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  // Default window of the 96-byte data RAM
  localparam logic [7:0] END_BASE_PADRAO = 8'd128;
  localparam logic [7:0] END_TOPO_PADRAO = 8'd223;

  // Port indices, also used as bit positions of the one-hot winner
  localparam logic PORTA_A = 1'b0;
  localparam logic PORTA_B = 1'b1;

  function automatic logic na_faixa(input logic [7:0] ad,
                                    input logic [7:0] base,
                                    input logic [7:0] topo);
    return (ad >= base) && (ad <= topo);
  endfunction

endpackage

// File: rtl/arbitro_memoria_seletor_rr.sv
// Two-way round-robin picker: one-hot winner among req_a/req_b.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module seletor_rr
  import arbitro_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ptr,       // index of the preferred port on a tie
  output logic [1:0] vencedor,  // bit PORTA_A / bit PORTA_B
  output logic       valido
);

  // A lone requester always wins; a tie goes to the preferred port
  always_comb begin
    vencedor = 2'b00;
    valido   = req_a | req_b;
    if (req_a && req_b) begin
      vencedor[ptr] = 1'b1;
    end else begin
      vencedor[PORTA_A] = req_a;
      vencedor[PORTA_B] = req_b;
    end
  end

endmodule

// File: rtl/arbitro_memoria.sv
// Arbitrates the single-port data RAM between the LSU (A) and an auxiliary master (B).
// Latency: gnt 1 cycle after sampled req; write pronto at +2, read pronto/data at +3.
// Backpressure: a losing request stays pending (req held) until it wins the next turn.
module arbitro_memoria
  import arbitro_pkg::*;
#(
  parameter logic [7:0] END_BASE = END_BASE_PADRAO,
  parameter logic [7:0] END_TOPO = END_TOPO_PADRAO
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic       we_a,
  input  logic [7:0] end_a,
  input  logic [7:0] dado_in_a,
  output logic       gnt_a,
  output logic       pronto_a,
  output logic [7:0] dado_out_a,
  output logic       erro_a,
  input  logic       req_b,
  input  logic       we_b,
  input  logic [7:0] end_b,
  input  logic [7:0] dado_in_b,
  output logic       gnt_b,
  output logic       pronto_b,
  output logic [7:0] dado_out_b,
  output logic       erro_b,
  output logic       mem_write,
  output logic [7:0] mem_endereco,
  output logic [7:0] mem_dado_in,
  input  logic [7:0] mem_dado_out,
  output logic       ocupado
);

  estado_t    estado_q;
  logic       pref_q;      // port preferred on the next tie
  logic       porta_q;     // port owning the current transaction
  logic       we_q;
  logic       faixa_q;     // registered address is inside the RAM window
  logic       gnt_a_q, gnt_b_q, pronto_a_q, pronto_b_q, erro_a_q, erro_b_q;
  logic [7:0] dado_out_a_q, dado_out_b_q;
  logic       mem_write_q;
  logic [7:0] mem_endereco_q, mem_dado_in_q;

  logic [1:0] vencedor;
  logic       valido;
  logic       porta_d;
  logic       we_d;
  logic [7:0] end_d, dado_d;
  logic       faixa_d;

  seletor_rr u_seletor (
    .req_a    (req_a),
    .req_b    (req_b),
    .ptr      (pref_q),
    .vencedor (vencedor),
    .valido   (valido)
  );

  // Route the winning port's command towards the command registers
  always_comb begin
    porta_d = vencedor[PORTA_B];
    we_d    = (porta_d == PORTA_B) ? we_b      : we_a;
    end_d   = (porta_d == PORTA_B) ? end_b     : end_a;
    dado_d  = (porta_d == PORTA_B) ? dado_in_b : dado_in_a;
    faixa_d = na_faixa(end_d, END_BASE, END_TOPO);
  end

  // Transaction FSM; every output is a register so a reset clears them at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q       <= OCIOSO;
      pref_q         <= PORTA_A;
      porta_q        <= PORTA_A;
      we_q           <= 1'b0;
      faixa_q        <= 1'b0;
      gnt_a_q        <= 1'b0;
      gnt_b_q        <= 1'b0;
      pronto_a_q     <= 1'b0;
      pronto_b_q     <= 1'b0;
      erro_a_q       <= 1'b0;
      erro_b_q       <= 1'b0;
      dado_out_a_q   <= 8'h00;
      dado_out_b_q   <= 8'h00;
      mem_write_q    <= 1'b0;
      mem_endereco_q <= 8'h00;
      mem_dado_in_q  <= 8'h00;
    end else begin
      // Pulses last a single cycle unless re-asserted below
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      pronto_a_q  <= 1'b0;
      pronto_b_q  <= 1'b0;
      erro_a_q    <= 1'b0;
      erro_b_q    <= 1'b0;
      mem_write_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          // Park the RAM on an address outside its window
          mem_endereco_q <= 8'h00;
          mem_dado_in_q  <= 8'h00;
          if (valido) begin
            porta_q        <= porta_d;
            we_q           <= we_d;
            faixa_q        <= faixa_d;
            mem_endereco_q <= end_d;
            mem_dado_in_q  <= dado_d;
            mem_write_q    <= we_d && faixa_d;
            gnt_a_q        <= (porta_d == PORTA_A);
            gnt_b_q        <= (porta_d == PORTA_B);
            pref_q         <= ~porta_d;  // the other port wins the next tie
            estado_q       <= EMITE;
          end
        end
        EMITE: begin
          if (!faixa_q || we_q) begin
            // Writes and out-of-range accesses finish without a read phase
            pronto_a_q     <= (porta_q == PORTA_A);
            pronto_b_q     <= (porta_q == PORTA_B);
            erro_a_q       <= (porta_q == PORTA_A) && !faixa_q;
            erro_b_q       <= (porta_q == PORTA_B) && !faixa_q;
            if (!faixa_q && porta_q == PORTA_A) dado_out_a_q <= 8'h00;
            if (!faixa_q && porta_q == PORTA_B) dado_out_b_q <= 8'h00;
            mem_endereco_q <= 8'h00;
            mem_dado_in_q  <= 8'h00;
            estado_q       <= OCIOSO;
          end else begin
            // Address stays on the bus while the RAM produces the data
            estado_q <= RESPOSTA;
          end
        end
        RESPOSTA: begin
          if (porta_q == PORTA_A) begin
            dado_out_a_q <= mem_dado_out;
            pronto_a_q   <= 1'b1;
          end else begin
            dado_out_b_q <= mem_dado_out;
            pronto_b_q   <= 1'b1;
          end
          mem_endereco_q <= 8'h00;
          mem_dado_in_q  <= 8'h00;
          estado_q       <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign gnt_a        = gnt_a_q;
  assign gnt_b        = gnt_b_q;
  assign pronto_a     = pronto_a_q;
  assign pronto_b     = pronto_b_q;
  assign erro_a       = erro_a_q;
  assign erro_b       = erro_b_q;
  assign dado_out_a   = dado_out_a_q;
  assign dado_out_b   = dado_out_b_q;
  assign mem_write    = mem_write_q;
  assign mem_endereco = mem_endereco_q;
  assign mem_dado_in  = mem_dado_in_q;
  assign ocupado      = (estado_q != OCIOSO);

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench for arbitro_memoria with a behavioural RAM and per-port scoreboards.
// Latency: checks grant/pronto cycle counts against the documented pipeline.
// Backpressure: exercises held and competing requests.
module tb_arbitro_memoria;

  logic       clock;
  logic       reset_n;
  logic       req_a, we_a, req_b, we_b;
  logic [7:0] end_a, dado_in_a, end_b, dado_in_b;
  logic       gnt_a, pronto_a, erro_a, gnt_b, pronto_b, erro_b;
  logic [7:0] dado_out_a, dado_out_b;
  logic       mem_write, ocupado;
  logic [7:0] mem_endereco, mem_dado_in, mem_dado_out;

  arbitro_memoria dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_a        (req_a),
    .we_a         (we_a),
    .end_a        (end_a),
    .dado_in_a    (dado_in_a),
    .gnt_a        (gnt_a),
    .pronto_a     (pronto_a),
    .dado_out_a   (dado_out_a),
    .erro_a       (erro_a),
    .req_b        (req_b),
    .we_b         (we_b),
    .end_b        (end_b),
    .dado_in_b    (dado_in_b),
    .gnt_b        (gnt_b),
    .pronto_b     (pronto_b),
    .dado_out_b   (dado_out_b),
    .erro_b       (erro_b),
    .mem_write    (mem_write),
    .mem_endereco (mem_endereco),
    .mem_dado_in  (mem_dado_in),
    .mem_dado_out (mem_dado_out),
    .ocupado      (ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural 96-byte RAM at 128..223, 1-cycle synchronous read
  logic [7:0] ram [0:95];
  logic       ram_ok;
  assign ram_ok = (mem_endereco >= 8'd128) && (mem_endereco <= 8'd223);
  initial for (int i = 0; i < 96; i++) ram[i] = 8'h00;
  always @(posedge clock) begin
    if (mem_write && ram_ok) ram[mem_endereco - 8'd128] <= mem_dado_in;
    mem_dado_out <= ram_ok ? ram[mem_endereco - 8'd128] : 8'h00;
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    compared++;
    if (obs !== esp) begin
      mismatched++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  typedef struct {
    logic       erro;
    logic       chk;
    logic [7:0] dado;
  } item_t;

  item_t q_a[$];
  item_t q_b[$];
  int    n_escr = 0;

  task automatic espera(input logic p, input logic e, input logic c, input logic [7:0] d);
    item_t it;
    it.erro = e;
    it.chk  = c;
    it.dado = d;
    if (p) q_b.push_back(it);
    else   q_a.push_back(it);
  endtask

  // Scoreboard: every pronto must match the oldest outstanding expectation of its port
  always @(negedge clock) begin
    item_t it;
    if (mem_write) n_escr++;
    if (pronto_a) begin
      verifica("pronto_a_pending", pronto_a, q_a.size() != 0);
      if (q_a.size() != 0) begin
        it = q_a.pop_front();
        verifica("erro_a", erro_a, it.erro);
        if (it.chk) verifica("dado_out_a", dado_out_a, it.dado);
      end
    end
    if (pronto_b) begin
      verifica("pronto_b_pending", pronto_b, q_b.size() != 0);
      if (q_b.size() != 0) begin
        it = q_b.pop_front();
        verifica("erro_b", erro_b, it.erro);
        if (it.chk) verifica("dado_out_b", dado_out_b, it.dado);
      end
    end
  end

  task automatic aciona(input logic p, input logic r, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
    if (p) begin req_b = r; we_b = w; end_b = a; dado_in_b = d; end
    else   begin req_a = r; we_a = w; end_a = a; dado_in_a = d; end
  endtask

  logic mw_gnt;

  // One transaction following the master rule; returns cycle of gnt and of pronto
  task automatic mestre(input logic p, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] ed, input logic ee, output int lg, output int lp);
    logic solta;
    espera(p, ee, !w || ee, ed);
    lg = -1;
    lp = -1;
    solta = 1'b0;
    @(posedge clock);
    #1 aciona(p, 1'b1, w, a, d);
    for (int n = 0; n < 40 && lp < 0; n++) begin
      if (solta) begin
        @(posedge clock);
        #1 aciona(p, 1'b0, 1'b0, 8'h00, 8'h00);
        solta = 1'b0;
      end
      @(negedge clock);
      if ((p ? gnt_b : gnt_a) && lg < 0) begin
        lg     = n;
        mw_gnt = mem_write;
        solta  = 1'b1;
      end
      if (p ? pronto_b : pronto_a) lp = n;
    end
    verifica("no_timeout", lp >= 0 && lg >= 0, 1'b1);
    if (solta) begin
      @(posedge clock);
      #1 aciona(p, 1'b0, 1'b0, 8'h00, 8'h00);
    end
  endtask

  task automatic reinicia();
    reset_n = 1'b0;
    aciona(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    aciona(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  int   lg, lp, lg2, lp2, e0, k;
  logic venc [0:7];
  logic ga [0:3];
  logic pa [0:3];

  initial begin
    reinicia();
    reset_n = 1'b0;
    #1;
    verifica("reset_port_a", {gnt_a, pronto_a, erro_a, dado_out_a}, 64'h0);
    verifica("reset_port_b", {gnt_b, pronto_b, erro_b, dado_out_b}, 64'h0);
    verifica("reset_mem", {mem_write, mem_endereco, mem_dado_in, ocupado}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: write then read on A
    e0 = n_escr;
    mestre(1'b0, 1'b1, 8'd130, 8'h5A, 8'h00, 1'b0, lg, lp);
    verifica("t1_w_gnt_cycle", lg, 1);
    verifica("t1_w_pronto_cycle", lp, 2);
    verifica("t1_mw_in_gnt", mw_gnt, 1'b1);
    verifica("t1_mw_cycles", n_escr - e0, 1);
    mestre(1'b0, 1'b0, 8'd130, 8'h00, 8'h5A, 1'b0, lg, lp);
    verifica("t1_r_gnt_cycle", lg, 1);
    verifica("t1_r_pronto_cycle", lp, 3);
    verifica("t1_ocupado_idle", ocupado, 1'b0);

    // 2: simultaneous reads, then both held continuously
    reinicia();
    fork
      mestre(1'b0, 1'b0, 8'd130, 8'h00, 8'h5A, 1'b0, lg, lp);
      mestre(1'b1, 1'b0, 8'd130, 8'h00, 8'h5A, 1'b0, lg2, lp2);
    join
    verifica("t2_a_gnt_cycle", lg, 1);
    verifica("t2_b_gnt_cycle", lg2, 4);
    verifica("t2_b_pronto_cycle", lp2, 6);
    @(posedge clock);
    #1;
    aciona(1'b0, 1'b1, 1'b0, 8'd130, 8'h00);
    aciona(1'b1, 1'b1, 1'b0, 8'd130, 8'h00);
    k = 0;
    for (int c = 0; c < 100 && k < 8; c++) begin
      @(negedge clock);
      if (gnt_a) begin venc[k] = 1'b0; k++; espera(1'b0, 1'b0, 1'b1, 8'h5A); end
      if (gnt_b && k < 8) begin venc[k] = 1'b1; k++; espera(1'b1, 1'b0, 1'b1, 8'h5A); end
    end
    verifica("t2_grant_count", k, 8);
    for (int i = 0; i < k; i++) verifica($sformatf("t2_alternate_%0d", i), venc[i], i % 2);
    @(posedge clock);
    #1;
    aciona(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    aciona(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (6) @(negedge clock);

    // 3: out-of-range accesses on B
    e0 = n_escr;
    mestre(1'b1, 1'b1, 8'd224, 8'hFF, 8'h00, 1'b1, lg, lp);
    verifica("t3_w_pronto_cycle", lp, 2);
    mestre(1'b1, 1'b0, 8'd127, 8'h00, 8'h00, 1'b1, lg, lp);
    verifica("t3_r_pronto_cycle", lp, 2);
    verifica("t3_no_mem_write", n_escr - e0, 0);
    mestre(1'b0, 1'b0, 8'd130, 8'h00, 8'h5A, 1'b0, lg, lp);

    // 4: window boundaries
    mestre(1'b0, 1'b1, 8'd128, 8'h11, 8'h00, 1'b0, lg, lp);
    mestre(1'b1, 1'b1, 8'd223, 8'h22, 8'h00, 1'b0, lg, lp);
    mestre(1'b1, 1'b0, 8'd128, 8'h00, 8'h11, 1'b0, lg, lp);
    mestre(1'b0, 1'b0, 8'd223, 8'h00, 8'h22, 1'b0, lg, lp);

    // 5: reset during the issue cycle of a write
    mestre(1'b0, 1'b1, 8'd150, 8'h00, 8'h00, 1'b0, lg, lp);
    @(posedge clock);
    #1 aciona(1'b0, 1'b1, 1'b1, 8'd150, 8'h77);
    @(negedge clock);
    @(negedge clock);
    verifica("t5_gnt_before_reset", gnt_a, 1'b1);
    verifica("t5_mw_before_reset", mem_write, 1'b1);
    #1;
    reset_n = 1'b0;
    aciona(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    verifica("t5_mw_async_drop", mem_write, 1'b0);
    verifica("t5_outputs_zero",
             {gnt_a, pronto_a, erro_a, dado_out_a, gnt_b, pronto_b, erro_b, dado_out_b,
              mem_endereco, mem_dado_in, ocupado}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      verifica("t5_no_pronto", pronto_a, 1'b0);
    end
    mestre(1'b0, 1'b0, 8'd150, 8'h00, 8'h00, 1'b0, lg, lp);

    // 6a: A holds req across its own pronto, B idle
    @(posedge clock);
    #1 aciona(1'b0, 1'b1, 1'b1, 8'd140, 8'h33);
    espera(1'b0, 1'b0, 1'b0, 8'h00);
    espera(1'b0, 1'b0, 1'b0, 8'h00);
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      ga[n] = gnt_a;
      pa[n] = pronto_a;
    end
    @(posedge clock);
    #1 aciona(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    verifica("t6_first_gnt", ga[1], 1'b1);
    verifica("t6_pronto", pa[2], 1'b1);
    verifica("t6_no_gnt_in_pronto", ga[2], 1'b0);
    verifica("t6_regrant_a", ga[3], 1'b1);
    repeat (4) @(negedge clock);

    // 6b: A holds req across pronto while B requests; B must win
    @(posedge clock);
    #1 aciona(1'b0, 1'b1, 1'b1, 8'd142, 8'h55);
    espera(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clock);
    @(negedge clock);
    verifica("t6b_gnt_a", gnt_a, 1'b1);
    @(posedge clock);
    #1 aciona(1'b1, 1'b1, 1'b1, 8'd143, 8'h66);
    espera(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clock);
    verifica("t6b_pronto_a", pronto_a, 1'b1);
    @(negedge clock);
    verifica("t6b_gnt_b", gnt_b, 1'b1);
    verifica("t6b_not_gnt_a", gnt_a, 1'b0);
    @(posedge clock);
    #1;
    aciona(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    aciona(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (4) @(negedge clock);
    mestre(1'b0, 1'b0, 8'd143, 8'h00, 8'h66, 1'b0, lg, lp);
    mestre(1'b1, 1'b0, 8'd140, 8'h00, 8'h33, 1'b0, lg, lp);

    repeat (3) @(negedge clock);
    verifica("queue_a_drained", q_a.size(), 0);
    verifica("queue_b_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
